// File: rtl/triangle_setup.sv
// triangle_setup
//   Upstream rasterizer stage. Collects 12 signed vertex words per triangle
//   (x,y,z,w for V1..V3), keeps x/y, applies the screen offset, builds the
//   bounding box, clamps it to the screen and drops degenerate boxes. One
//   descriptor per surviving triangle goes out on a valid/ready link.
//
//   Optional feature: define BACKFACE_CULL_EN to add an AREA state that
//   computes the signed edge function and drops triangles with E<0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_start         pulse: color <- 1, drop_cnt <- 0
//   in_valid/in_ready   vertex word handshake, in_data = signed M-bit word
//   tri_valid/tri_ready descriptor handshake
//   tri_v{1,2,3}_{x,y}  12-bit signed screen coordinates
//   tri_bb_*            clamped bounding box (half-open for the raster stage)
//   tri_color           color id of the descriptor
//   drop_cnt            saturating count of dropped triangles
module triangle_setup #(
    parameter int M     = 11,
    parameter int X_OFF = 400,
    parameter int Y_OFF = 300,
    parameter int X_MAX = 799,
    parameter int Y_MAX = 599
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_data,
    output logic         tri_valid,
    input  logic         tri_ready,
    output logic [11:0]  tri_v1_x,
    output logic [11:0]  tri_v1_y,
    output logic [11:0]  tri_v2_x,
    output logic [11:0]  tri_v2_y,
    output logic [11:0]  tri_v3_x,
    output logic [11:0]  tri_v3_y,
    output logic [9:0]   tri_bb_tl_x,
    output logic [9:0]   tri_bb_tl_y,
    output logic [9:0]   tri_bb_br_x,
    output logic [9:0]   tri_bb_br_y,
    output logic [7:0]   tri_color,
    output logic [15:0]  drop_cnt
);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_SETUP,
`ifdef BACKFACE_CULL_EN
        S_AREA,
`endif
        S_CHECK,
        S_EMIT
    } state_t;

    localparam logic signed [11:0] XMAX12 = 12'(X_MAX);
    localparam logic signed [11:0] YMAX12 = 12'(Y_MAX);

    state_t r_state, w_state_nxt;

    logic [3:0]          r_idx;
    logic [M-1:0]        r_wx [3];
    logic [M-1:0]        r_wy [3];
    logic signed [11:0]  r_vx [3];
    logic signed [11:0]  r_vy [3];
    logic signed [11:0]  r_minx, r_maxx, r_miny, r_maxy;
    logic [9:0]          r_tlx, r_tly, r_brx, r_bry;
    logic [7:0]          r_color, r_tri_color;
    logic [15:0]         r_drop;

    logic signed [11:0]  w_sx [3];
    logic signed [11:0]  w_sy [3];
    logic [9:0]          w_tlx, w_tly, w_brx, w_bry;
    logic                w_hs_in, w_hs_out, w_drop;

    function automatic logic signed [11:0] min3(input logic signed [11:0] a, b, c);
        logic signed [11:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [11:0] max3(input logic signed [11:0] a, b, c);
        logic signed [11:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic signed [11:0] mx);
        if (v < 12'sd0)
            return 10'd0;
        else if (v > mx)
            return mx[9:0];
        else
            return v[9:0];
    endfunction

    // Sign-extend captured words and apply the screen offset.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_sx[i] = {{(12-M){r_wx[i][M-1]}}, r_wx[i]} + 12'(X_OFF);
            w_sy[i] = {{(12-M){r_wy[i][M-1]}}, r_wy[i]} + 12'(Y_OFF);
        end
    end

    assign w_tlx = clamp(r_minx, XMAX12);
    assign w_brx = clamp(r_maxx, XMAX12);
    assign w_tly = clamp(r_miny, YMAX12);
    assign w_bry = clamp(r_maxy, YMAX12);

`ifdef BACKFACE_CULL_EN
    // Edge function on screen coords; 13-bit differences keep the full range.
    logic signed [12:0] w_dx2, w_dy2, w_dx3, w_dy3;
    logic signed [25:0] w_pa, w_pb, w_e;
    logic signed [24:0] r_area;

    always_comb begin
        w_dx2 = {r_vx[1][11], r_vx[1]} - {r_vx[0][11], r_vx[0]};
        w_dy2 = {r_vy[1][11], r_vy[1]} - {r_vy[0][11], r_vy[0]};
        w_dx3 = {r_vx[2][11], r_vx[2]} - {r_vx[0][11], r_vx[0]};
        w_dy3 = {r_vy[2][11], r_vy[2]} - {r_vy[0][11], r_vy[0]};
        w_pa  = w_dx3 * w_dy2;
        w_pb  = w_dy3 * w_dx2;
        w_e   = w_pa - w_pb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_area <= '0;
        else if (r_state == S_AREA)
            r_area <= w_e[24:0];
    end

    assign w_drop = (w_tlx == w_brx) || (w_tly == w_bry) || (r_area < 25'sd0);
`else
    assign w_drop = (w_tlx == w_brx) || (w_tly == w_bry);
`endif

    // Handshake flags depend only on the state register, never on tri_ready.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == S_COLLECT);
        tri_valid   = (r_state == S_EMIT);
        w_hs_in     = in_valid && (r_state == S_COLLECT);
        w_hs_out    = tri_ready && (r_state == S_EMIT);
        case (r_state)
            S_COLLECT: if (w_hs_in && r_idx == 4'd11) w_state_nxt = S_SETUP;
`ifdef BACKFACE_CULL_EN
            S_SETUP:   w_state_nxt = S_AREA;
            S_AREA:    w_state_nxt = S_CHECK;
`else
            S_SETUP:   w_state_nxt = S_CHECK;
`endif
            S_CHECK:   w_state_nxt = w_drop ? S_COLLECT : S_EMIT;
            S_EMIT:    if (w_hs_out) w_state_nxt = S_COLLECT;
            default:   w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_COLLECT;
        else
            r_state <= w_state_nxt;
    end

    // Word capture: only x/y of each vertex are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            for (int i = 0; i < 3; i++) begin
                r_wx[i] <= '0;
                r_wy[i] <= '0;
            end
        end else if (w_hs_in) begin
            r_idx <= (r_idx == 4'd11) ? 4'd0 : r_idx + 4'd1;
            case (r_idx)
                4'd0:    r_wx[0] <= in_data;
                4'd1:    r_wy[0] <= in_data;
                4'd4:    r_wx[1] <= in_data;
                4'd5:    r_wy[1] <= in_data;
                4'd8:    r_wx[2] <= in_data;
                4'd9:    r_wy[2] <= in_data;
                default: ;
            endcase
        end
    end

    // Setup: screen vertices and raw box; check: clamped box and color latch.
    // Outputs only change outside EMIT, so they hold until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
            r_minx      <= '0;
            r_maxx      <= '0;
            r_miny      <= '0;
            r_maxy      <= '0;
            r_tlx       <= '0;
            r_tly       <= '0;
            r_brx       <= '0;
            r_bry       <= '0;
            r_tri_color <= '0;
        end else if (r_state == S_SETUP) begin
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= w_sx[i];
                r_vy[i] <= w_sy[i];
            end
            r_minx <= min3(w_sx[0], w_sx[1], w_sx[2]);
            r_maxx <= max3(w_sx[0], w_sx[1], w_sx[2]);
            r_miny <= min3(w_sy[0], w_sy[1], w_sy[2]);
            r_maxy <= max3(w_sy[0], w_sy[1], w_sy[2]);
        end else if (r_state == S_CHECK && !w_drop) begin
            r_tlx       <= w_tlx;
            r_tly       <= w_tly;
            r_brx       <= w_brx;
            r_bry       <= w_bry;
            r_tri_color <= r_color;
        end
    end

    // frame_start overrides both the color step and the drop count step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_color <= 8'd1;
            r_drop  <= '0;
        end else if (frame_start) begin
            r_color <= 8'd1;
            r_drop  <= '0;
        end else begin
            if (w_hs_out)
                r_color <= r_color + 8'd1;
            if (r_state == S_CHECK && w_drop && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    assign tri_v1_x    = r_vx[0];
    assign tri_v1_y    = r_vy[0];
    assign tri_v2_x    = r_vx[1];
    assign tri_v2_y    = r_vy[1];
    assign tri_v3_x    = r_vx[2];
    assign tri_v3_y    = r_vy[2];
    assign tri_bb_tl_x = r_tlx;
    assign tri_bb_tl_y = r_tly;
    assign tri_bb_br_x = r_brx;
    assign tri_bb_br_y = r_bry;
    assign tri_color   = r_tri_color;
    assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_triangle_setup.sv
module tb_triangle_setup;

`ifdef BACKFACE_CULL_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 0, rst_n = 0, frame_start = 0, in_valid = 0, tri_ready = 1;
    logic        in_ready, tri_valid;
    logic [10:0] in_data = '0;
    logic [11:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic [9:0]  tlx, tly, brx, bry;
    logic [7:0]  tcol;
    logic [15:0] dcnt;

    triangle_setup dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_v1_x(v1x), .tri_v1_y(v1y), .tri_v2_x(v2x), .tri_v2_y(v2y),
        .tri_v3_x(v3x), .tri_v3_y(v3y),
        .tri_bb_tl_x(tlx), .tri_bb_br_x(brx), .tri_bb_tl_y(tly), .tri_bb_br_y(bry),
        .tri_color(tcol), .drop_cnt(dcnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] v;
        logic [39:0] bb;
        logic [7:0]  col;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0, n_fail = 0;
    int   m_color = 1, m_drop = 0;
    int   tw[12];

    wire [71:0] cur_v  = {v1x, v1y, v2x, v2y, v3x, v3y};
    wire [39:0] cur_bb = {tlx, tly, brx, bry};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every descriptor handshake pops one expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && tri_valid && tri_ready) begin
            if (sb.size() == 0)
                check("unexpected_tri", 1, 0);
            else begin
                e = sb.pop_front();
                check("tri_verts", cur_v, e.v);
                check("tri_box", cur_bb, e.bb);
                check("tri_color", tcol, e.col);
            end
        end
    end

    task automatic send_word(input int w);
        int k;
        in_valid = 1;
        in_data  = w[10:0];
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    // Sends tw[], predicts the outcome and checks latency or drop count.
    // With tri_ready low it returns while the descriptor sits in EMIT.
    task automatic run_tri();
        int vx[3], vy[3];
        int mnx, mxx, mny, mxy, c;
        longint e;
        bit drop;
        exp_t ex;
        for (int i = 0; i < 12; i++) send_word(tw[i]);
        for (int i = 0; i < 3; i++) begin
            vx[i] = tw[4*i] + 400;
            vy[i] = tw[4*i+1] + 300;
        end
        mnx = vx[0]; mxx = vx[0]; mny = vy[0]; mxy = vy[0];
        for (int i = 1; i < 3; i++) begin
            if (vx[i] < mnx) mnx = vx[i];
            if (vx[i] > mxx) mxx = vx[i];
            if (vy[i] < mny) mny = vy[i];
            if (vy[i] > mxy) mxy = vy[i];
        end
        mnx = clampi(mnx, 799); mxx = clampi(mxx, 799);
        mny = clampi(mny, 599); mxy = clampi(mxy, 599);
        drop = (mnx == mxx) || (mny == mxy);
        e = longint'(vx[2] - vx[0]) * (vy[1] - vy[0]) - longint'(vy[2] - vy[0]) * (vx[1] - vx[0]);
`ifdef BACKFACE_CULL_EN
        if (e < 0) drop = 1;
`endif
        if (!drop) begin
            ex.v   = {12'(vx[0]), 12'(vy[0]), 12'(vx[1]), 12'(vy[1]), 12'(vx[2]), 12'(vy[2])};
            ex.bb  = {10'(mnx), 10'(mny), 10'(mxx), 10'(mxy)};
            ex.col = 8'(m_color);
            sb.push_back(ex);
            m_color = (m_color + 1) % 256;
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!tri_valid && c < 20);
            check("latency", c, LAT);
            if (tri_ready) begin
                @(posedge clk); #1;
            end
        end else begin
            if (m_drop < 65535) m_drop++;
            repeat (LAT) @(negedge clk);
            check("drop_no_valid", tri_valid, 0);
            check("drop_cnt", dcnt, m_drop);
            check("drop_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int ox, oy;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {cur_v, cur_bb, tcol}, 0);
        check("rst_flags", {in_ready, tri_valid}, 2'b10);
        check("rst_drop", dcnt, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // 1: basic triangle
        tw = '{-100, -100, 0, 0, 0, 100, 0, 0, 100, -100, 0, 0};
        run_tri();
        // 2: V2/V3 swapped, negative winding
        tw = '{-100, -100, 0, 0, 100, -100, 0, 0, 0, 100, 0, 0};
        run_tri();
        // 3: zero-width box
        tw = '{0, -50, 0, 0, 0, 0, 0, 0, 0, 50, 0, 0};
        run_tri();
        tw = '{-100, -100, 0, 0, 0, 100, 0, 0, 100, -100, 0, 0};
        run_tri();
        // 4: box clamped on every side
        tw = '{-500, -400, 0, 0, 500, 400, 0, 0, -500, 400, 0, 0};
        run_tri();
        // extreme words, clamped both ways
        tw = '{-1024, -1024, 5, 5, 1023, 1023, 7, 7, 1023, -1024, 9, 9};
        run_tri();
        // box entirely right of the screen collapses to X_MAX
        tw = '{500, -50, 0, 0, 600, 0, 0, 0, 700, 50, 0, 0};
        run_tri();

        // 5: back-pressure in EMIT, then frame_start on the output handshake
        tri_ready = 0;
        tw = '{-100, -100, 0, 0, 0, 100, 0, 0, 100, -100, 0, 0};
        run_tri();
        in_valid = 1;
        in_data  = 11'h123;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", tri_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_verts", cur_v, sb[0].v);
            check("hold_box", cur_bb, sb[0].bb);
            check("hold_color", tcol, sb[0].col);
        end
        @(posedge clk); #1;
        tri_ready   = 1;
        frame_start = 1;
        @(posedge clk); #1;
        frame_start = 0;
        in_valid    = 0;
        m_color = 1;
        m_drop  = 0;
        check("fs_drop_clr", dcnt, 0);
        check("fs_in_ready", in_ready, 1);
        check("fs_sb_empty", sb.size(), 0);
        run_tri();

        // 6: reset mid-triangle, then color wrap
        for (int i = 0; i < 7; i++) send_word(tw[i]);
        rst_n = 0;
        @(negedge clk);
        check("rst2_outputs", {cur_v, cur_bb, tcol, dcnt}, 0);
        @(negedge clk);
        rst_n = 1;
        m_color = 1;
        m_drop  = 0;
        @(posedge clk); #1;
        run_tri();
        for (int n = 0; n < 256; n++) begin
            ox = $urandom_range(300, 0) - 150;
            oy = $urandom_range(200, 0) - 100;
            tw = '{-100 + ox, -100 + oy, 0, 0, ox, 100 + oy, 0, 0, 100 + ox, -100 + oy, 0, 0};
            run_tri();
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
